// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between decoder logic and the PC sequencer
//   halt, op, dir, cond, offset, target : control from decoder/CPSR (master -> slave)
//   PC, redirect, sp, ovf, unf, cycles  : sequencer state (slave -> master)
interface pc_sequencer_if #(
    parameter int PC_W        = 8,
    parameter int OFF_W       = 5,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 32
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    logic             halt;
    logic [2:0]       op;
    logic             dir;
    logic             cond;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  PC;
    logic             redirect;
    logic [SP_W-1:0]  sp;
    logic             ovf;
    logic             unf;
    logic [CNT_W-1:0] cycles;
    modport master (output halt, op, dir, cond, offset, target,
                    input  PC, redirect, sp, ovf, unf, cycles);
    modport slave  (input  halt, op, dir, cond, offset, target,
                    output PC, redirect, sp, ovf, unf, cycles);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with relative branch, jump, call/return stack and cycle counter
//   CLK  : clock, all state updates on posedge
//   init : synchronous active-high reset
//   bus  : slave side of pc_sequencer_if (control in, PC/stack/status out)
module pc_sequencer #(
    parameter int PC_W        = 8,
    parameter int OFF_W       = 5,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 32
) (
    input logic           CLK,
    input logic           init,
    pc_sequencer_if.slave bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [PC_W-1:0]  pc, pc_inc, off_ext, nxt_pc;
    logic [SP_W-1:0]  sp, sp_dec;
    logic [CNT_W-1:0] cycles;
    logic             redirect, ovf, unf;
    logic             brel, jmp, call, ret, full, empty, push, pop;
    logic [PC_W-1:0]  stack [STACK_DEPTH];
    // cond=0 demotes BREL/JMP/CALL to SEQ; RET ignores cond
    assign brel    = bus.op == 3'd1 && bus.cond;
    assign jmp     = bus.op == 3'd2 && bus.cond;
    assign call    = bus.op == 3'd3 && bus.cond;
    assign ret     = bus.op == 3'd4;
    assign full    = sp == SP_W'(STACK_DEPTH);
    assign empty   = sp == '0;
    assign push    = call && !full;
    assign pop     = ret && !empty;
    assign pc_inc  = pc + 1'b1;
    assign off_ext = PC_W'(bus.offset);
    assign sp_dec  = sp - 1'b1;
    // index slices are only used when push/pop is legal, so they never exceed the array
    assign nxt_pc  = brel ? (bus.dir ? pc - off_ext : pc + off_ext) :
                     (jmp || push) ? bus.target :
                     pop ? stack[sp_dec[IDX_W-1:0]] : pc_inc;
    always_ff @(posedge CLK) begin
        if (!init && !bus.halt && push)
            stack[sp[IDX_W-1:0]] <= pc_inc;
    end
    always_ff @(posedge CLK) begin
        if (init) begin
            pc       <= '0;
            redirect <= 1'b0;
            sp       <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            cycles   <= '0;
        end else begin
            cycles <= cycles + 1'b1;
            if (bus.halt) begin
                redirect <= 1'b0;
            end else begin
                pc       <= nxt_pc;
                redirect <= brel || jmp || push || pop;
                if (push)
                    sp <= sp + 1'b1;
                if (pop)
                    sp <= sp_dec;
                if (call && full)
                    ovf <= 1'b1;
                if (ret && empty)
                    unf <= 1'b1;
            end
        end
    end
    assign bus.PC       = pc;
    assign bus.redirect = redirect;
    assign bus.sp       = sp;
    assign bus.ovf      = ovf;
    assign bus.unf      = unf;
    assign bus.cycles   = cycles;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven scoreboard bench for pc_sequencer at default parameters
module tb_pc_sequencer;
    localparam int SEQ = 0, BREL = 1, JMP = 2, CALL = 3, RET = 4;
    typedef struct packed {
        logic       init;
        logic       halt;
        logic [2:0] op;
        logic       dir;
        logic       cond;
        logic [4:0] offset;
        logic [7:0] target;
        logic [7:0] pc;
        logic       red;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
    } vec_t;
    typedef struct packed {
        logic [7:0]  pc;
        logic        red;
        logic [2:0]  sp;
        logic        ovf;
        logic        unf;
        logic [31:0] cyc;
    } exp_t;
    logic        CLK = 1'b0;
    logic        init;
    vec_t        tbl[$];
    exp_t        exp_q[$];
    logic [31:0] exp_cyc = '0;
    int          errors = 0;
    int          checks = 0;
    pc_sequencer_if #(.PC_W(8), .OFF_W(5), .STACK_DEPTH(4), .CNT_W(32)) bus ();
    pc_sequencer #(.PC_W(8), .OFF_W(5), .STACK_DEPTH(4), .CNT_W(32)) dut (
        .CLK (CLK),
        .init(init),
        .bus (bus)
    );
    always #5 CLK = ~CLK;
    function automatic vec_t mk(int i, int h, int o, int d, int c, int off, int tg,
                                int pc, int r, int sp, int ov, int un);
        return '{i[0], h[0], o[2:0], d[0], c[0], off[4:0], tg[7:0],
                 pc[7:0], r[0], sp[2:0], ov[0], un[0]};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask
    // drive one cycle of stimulus and queue its expected post-edge state
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge CLK);
        init       = v.init;
        bus.halt   = v.halt;
        bus.op     = v.op;
        bus.dir    = v.dir;
        bus.cond   = v.cond;
        bus.offset = v.offset;
        bus.target = v.target;
        exp_cyc    = v.init ? 32'd0 : exp_cyc + 32'd1;
        e = '{v.pc, v.red, v.sp, v.ovf, v.unf, exp_cyc};
        exp_q.push_back(e);
    endtask
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", 32'(bus.PC), 32'(e.pc));
            chk("redirect", 32'(bus.redirect), 32'(e.red));
            chk("sp", 32'(bus.sp), 32'(e.sp));
            chk("ovf", 32'(bus.ovf), 32'(e.ovf));
            chk("unf", 32'(bus.unf), 32'(e.unf));
            chk("cycles", bus.cycles, e.cyc);
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        init = 1'b1; bus.halt = 1'b0; bus.op = '0; bus.dir = 1'b0;
        bus.cond = 1'b0; bus.offset = '0; bus.target = '0;
        //                 i h op   d c off tg    pc   r sp ov un
        tbl.push_back(mk(1, 0, SEQ, 0, 0, 0, 0,    0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    1,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    2,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    3,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    4,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, JMP, 0, 1, 0, 10,   10,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, BREL, 0, 1, 5, 0,   15,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, BREL, 1, 1, 20, 0,  251, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, BREL, 0, 1, 0, 0,   251, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    252, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    253, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    254, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    255, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, JMP, 0, 1, 0, 7,    7,   1, 0, 0, 0));
        tbl.push_back(mk(0, 0, CALL, 0, 1, 0, 'h40, 'h40, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    'h41, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, SEQ, 0, 0, 0, 0,    'h42, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, RET, 0, 0, 0, 0,    8,   1, 0, 0, 0));
        tbl.push_back(mk(0, 0, JMP, 0, 1, 0, 'h60, 'h60, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, CALL, 0, 1, 0, 'h10, 'h10, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, CALL, 0, 1, 0, 'h20, 'h20, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, CALL, 0, 1, 0, 'h30, 'h30, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, CALL, 0, 1, 0, 'h40, 'h40, 1, 4, 0, 0));
        tbl.push_back(mk(0, 0, CALL, 0, 1, 0, 'h50, 'h41, 0, 4, 1, 0));
        tbl.push_back(mk(0, 0, RET, 0, 0, 0, 0,    'h31, 1, 3, 1, 0));
        tbl.push_back(mk(0, 0, RET, 0, 0, 0, 0,    'h21, 1, 2, 1, 0));
        tbl.push_back(mk(0, 0, RET, 0, 0, 0, 0,    'h11, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, RET, 0, 0, 0, 0,    'h61, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, RET, 0, 0, 0, 0,    'h62, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, CALL, 0, 0, 0, 'h99, 'h63, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, JMP, 0, 0, 0, 'h99, 'h64, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, BREL, 1, 0, 9, 0,   'h65, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 5, 0, 1, 3, 'h99,   'h66, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 7, 1, 1, 3, 'h99,   'h67, 0, 0, 1, 1));
        foreach (tbl[i]) apply(tbl[i]);
        // halt over JMP/RET: PC, sp and stack frozen, redirect drops, cycles keeps counting
        apply(mk(0, 0, JMP, 0, 1, 0, 'h70,  'h70, 1, 0, 1, 1));
        apply(mk(0, 0, CALL, 0, 1, 0, 'h20, 'h20, 1, 1, 1, 1));
        apply(mk(0, 1, JMP, 0, 1, 0, 'h10,  'h20, 0, 1, 1, 1));
        apply(mk(0, 1, JMP, 0, 1, 0, 'h10,  'h20, 0, 1, 1, 1));
        apply(mk(0, 1, JMP, 0, 1, 0, 'h10,  'h20, 0, 1, 1, 1));
        apply(mk(0, 1, RET, 0, 0, 0, 0,     'h20, 0, 1, 1, 1));
        apply(mk(0, 0, JMP, 0, 0, 0, 'h10,  'h21, 0, 1, 1, 1));
        apply(mk(0, 0, RET, 0, 0, 0, 0,     'h71, 1, 0, 1, 1));
        // init overrides a CALL with sp=2 and sticky flags set
        apply(mk(0, 0, CALL, 0, 1, 0, 'h80, 'h80, 1, 1, 1, 1));
        apply(mk(0, 0, CALL, 0, 1, 0, 'h90, 'h90, 1, 2, 1, 1));
        apply(mk(1, 0, CALL, 0, 1, 0, 'hAA, 0,    0, 0, 0, 0));
        apply(mk(0, 0, SEQ, 0, 0, 0, 0,     1,    0, 0, 0, 0));
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
